// File: rtl/scratch_pad_pp.sv
// Ping-pong banked scratch pad: the host fills one buffer in IN_WIDTH slices while the
// array side streams full lines from the other; ownership moves via commit / rd_done.
module scratch_pad_pp #(
    parameter int WIDTH      = 16,
    parameter int SYS_WIDTH  = 64,
    parameter int SYS_HEIGHT = 1,
    parameter int LINE_WIDTH = 64,
    parameter int IN_WIDTH   = 32,
    parameter int DEPTH      = 8,
    localparam int NB        = SYS_HEIGHT + SYS_WIDTH,
    localparam int SLICES    = LINE_WIDTH / IN_WIDTH,
    localparam int HB        = $clog2(SLICES),
    localparam int BB        = $clog2(NB),
    localparam int LB        = $clog2(DEPTH),
    localparam int AW        = HB + BB + LB
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wen,
    input  logic [AW-1:0]                    wr_addr,
    input  logic [IN_WIDTH-1:0]              wr_data,
    input  logic                             commit,
    output logic                             fill_ready,
    output logic                             rd_avail,
    input  logic                             rd_en,
    input  logic [LB-1:0]                    rd_line,
    input  logic                             rd_done,
    output logic                             rd_valid,
    output logic [SYS_HEIGHT*LINE_WIDTH-1:0] data_out_a,
    output logic [SYS_WIDTH*LINE_WIDTH-1:0]  data_out_b,
    input  logic                             err_clr,
    output logic                             err_wr,
    output logic                             err_addr
);

    // Elaboration-time guards on the parameter relationships the addressing relies on.
    if (LINE_WIDTH % WIDTH != 0) begin : g_chk_width
        $error("scratch_pad_pp: LINE_WIDTH must be a multiple of WIDTH");
    end
    if ((LINE_WIDTH % IN_WIDTH != 0) || (SLICES & (SLICES - 1)) != 0 || SLICES < 2) begin : g_chk_in_width
        $error("scratch_pad_pp: LINE_WIDTH/IN_WIDTH must be a power of two >= 2");
    end
    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("scratch_pad_pp: DEPTH must be a power of two");
    end

    typedef enum logic {
        BUF_FREE = 1'b0,
        BUF_FULL = 1'b1
    } buf_state_t;

    buf_state_t buf_state     [2];
    buf_state_t buf_state_nxt [2];
    logic       wr_ptr, wr_ptr_nxt;
    logic       rd_ptr, rd_ptr_nxt;

    logic [HB-1:0] wr_half;
    logic [BB-1:0] wr_bank;
    logic [LB-1:0] wr_line;
    logic          bank_ok;
    logic          wr_fire;
    logic          rd_fire;
    logic          wr_err_evt;
    logic          addr_err_evt;

    assign wr_half = wr_addr[HB-1:0];
    assign wr_bank = wr_addr[HB+BB-1:HB];
    assign wr_line = wr_addr[AW-1:HB+BB];
    assign bank_ok = ({1'b0, wr_bank} < (BB+1)'(NB));

    assign fill_ready = (buf_state[wr_ptr] == BUF_FREE);
    assign rd_avail   = (buf_state[rd_ptr] == BUF_FULL);

    assign wr_fire      = wen && fill_ready && bank_ok;
    assign rd_fire      = rd_en && rd_avail;
    assign wr_err_evt   = (wen || commit) && !fill_ready;
    assign addr_err_evt = wen && !bank_ok;

    // Commit and rd_done always target different buffers (one is FREE, the other FULL),
    // so both may apply in the same cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        buf_state_nxt = buf_state;
        wr_ptr_nxt    = wr_ptr;
        rd_ptr_nxt    = rd_ptr;
        if (commit && fill_ready) begin
            buf_state_nxt[wr_ptr] = BUF_FULL;
            wr_ptr_nxt            = ~wr_ptr;
        end
        if (rd_done && rd_avail) begin
            buf_state_nxt[rd_ptr] = BUF_FREE;
            rd_ptr_nxt            = ~rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            buf_state <= '{default: BUF_FREE};
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
        end else begin
            buf_state <= buf_state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
        end
    end

    // Sticky errors: a new event in the clearing cycle still sets the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_wr   <= 1'b0;
            err_addr <= 1'b0;
        end else begin
            err_wr   <= (err_wr   && !err_clr) || wr_err_evt;
            err_addr <= (err_addr && !err_clr) || addr_err_evt;
        end
    end

    // Read pipeline: request register -> RAM register -> output register.
    logic          req_v;
    logic [LB:0]   req_addr;
    logic          ram_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_v    <= 1'b0;
            ram_v    <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            req_v    <= rd_fire;
            ram_v    <= req_v;
            rd_valid <= ram_v;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_fire) begin
            req_addr <= {rd_ptr, rd_line};
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        // Both buffers of this bank share one array, addressed by {buffer, line}.
        logic [LINE_WIDTH-1:0] mem [2*DEPTH];
        logic [LINE_WIDTH-1:0] ram_q;
        logic [LINE_WIDTH-1:0] out_q;
        logic                  bank_we;

        assign bank_we = wr_fire && (wr_bank == BB'(b));

        // NOTE: the storage array and its read register are deliberately not reset; only
        // the visible output register is, so reset stays cheap and contents survive it.
        always_ff @(posedge clk) begin
            if (bank_we) begin
                for (int s = 0; s < SLICES; s++) begin
                    if (wr_half == HB'(s)) begin
                        mem[{wr_ptr, wr_line}][s*IN_WIDTH +: IN_WIDTH] <= wr_data;
                    end
                end
            end
            if (req_v) begin
                ram_q <= mem[req_addr];
            end
        end

        // Output holds its last line while no read is completing.
        always_ff @(posedge clk) begin
            if (rst) begin
                out_q <= '0;
            end else if (ram_v) begin
                out_q <= ram_q;
            end
        end

        if (b < SYS_HEIGHT) begin : g_a
            assign data_out_a[b*LINE_WIDTH +: LINE_WIDTH] = out_q;
        end else begin : g_b
            assign data_out_b[(b-SYS_HEIGHT)*LINE_WIDTH +: LINE_WIDTH] = out_q;
        end
    end

endmodule

// File: tb/tb_scratch_pad_pp.sv
// Directed bench for scratch_pad_pp: reset, fill/stream, ping-pong handoff, same-cycle
// commit/done, bad-bank errors and reset during an in-flight read.
module tb_scratch_pad_pp;

    localparam int SYS_WIDTH  = 64;
    localparam int SYS_HEIGHT = 1;
    localparam int LINE_WIDTH = 64;
    localparam int IN_WIDTH   = 32;
    localparam int NB         = 65;
    localparam int AW         = 11;
    localparam int LB         = 3;

    logic                             clk;
    logic                             rst;
    logic                             wen;
    logic [AW-1:0]                    wr_addr;
    logic [IN_WIDTH-1:0]              wr_data;
    logic                             commit;
    logic                             fill_ready;
    logic                             rd_avail;
    logic                             rd_en;
    logic [LB-1:0]                    rd_line;
    logic                             rd_done;
    logic                             rd_valid;
    logic [SYS_HEIGHT*LINE_WIDTH-1:0] data_out_a;
    logic [SYS_WIDTH*LINE_WIDTH-1:0]  data_out_b;
    logic                             err_clr;
    logic                             err_wr;
    logic                             err_addr;

    int checks   = 0;
    int failures = 0;

    scratch_pad_pp dut (
        .clk        (clk),
        .rst        (rst),
        .wen        (wen),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit     (commit),
        .fill_ready (fill_ready),
        .rd_avail   (rd_avail),
        .rd_en      (rd_en),
        .rd_line    (rd_line),
        .rd_done    (rd_done),
        .rd_valid   (rd_valid),
        .data_out_a (data_out_a),
        .data_out_b (data_out_b),
        .err_clr    (err_clr),
        .err_wr     (err_wr),
        .err_addr   (err_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    function automatic logic [AW-1:0] mk_addr(int k, int b, int h);
        return {3'(k), 7'(b), 1'(h)};
    endfunction

    // Buffer 1 contents carry a tag so they cannot be confused with buffer 0.
    function automatic logic [31:0] word_of(int tag, int k, int b, int h);
        return (tag != 0 ? 32'h00A5_0000 : 32'h0) | 32'(mk_addr(k, b, h));
    endfunction

    function automatic logic [63:0] line_of(int tag, int k, int b);
        return {word_of(tag, k, b, 1), word_of(tag, k, b, 0)};
    endfunction

    function automatic logic [SYS_WIDTH*LINE_WIDTH-1:0] exp_b(int tag, int k);
        logic [SYS_WIDTH*LINE_WIDTH-1:0] r;
        for (int b = 1; b < NB; b++) r[(b-1)*LINE_WIDTH +: LINE_WIDTH] = line_of(tag, k, b);
        return r;
    endfunction

    task automatic fill_buffer(int tag);
        for (int k = 0; k < 8; k++)
            for (int b = 0; b < NB; b++)
                for (int h = 0; h < 2; h++) begin
                    wen = 1'b1; wr_addr = mk_addr(k, b, h); wr_data = word_of(tag, k, b, h);
                    @(negedge clk);
                end
        wen = 1'b0;
    endtask

    task automatic write_word(logic [AW-1:0] a, logic [IN_WIDTH-1:0] d);
        wen = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1; @(negedge clk); commit = 1'b0;
    endtask

    task automatic pulse_done();
        rd_done = 1'b1; @(negedge clk); rd_done = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (fill_ready !== 1'b1) begin failures++; $display("FAIL reset_fill_ready got=%b exp=1", fill_ready); end
        checks++; if (rd_avail !== 1'b0) begin failures++; $display("FAIL reset_rd_avail got=%b exp=0", rd_avail); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        checks++; if (data_out_a !== '0) begin failures++; $display("FAIL reset_data_a got=%h exp=0", data_out_a); end
        checks++; if (data_out_b !== '0) begin failures++; $display("FAIL reset_data_b bank1 got=%h exp=0", data_out_b[63:0]); end
        checks++; if (err_wr !== 1'b0) begin failures++; $display("FAIL reset_err_wr got=%b exp=0", err_wr); end
        checks++; if (err_addr !== 1'b0) begin failures++; $display("FAIL reset_err_addr got=%b exp=0", err_addr); end
    endtask

    // Fill buffer 0, commit, then stream all eight lines back-to-back.
    task automatic test_fill_read_stream();
        logic exp_v;
        int   kk;
        fill_buffer(0);
        pulse_commit();
        checks++; if (fill_ready !== 1'b1) begin failures++; $display("FAIL stream_fill_ready got=%b exp=1", fill_ready); end
        checks++; if (rd_avail !== 1'b1) begin failures++; $display("FAIL stream_rd_avail got=%b exp=1", rd_avail); end
        for (int c = 0; c < 12; c++) begin
            exp_v = (c >= 3 && c <= 10);
            checks++;
            if (rd_valid !== exp_v) begin
                failures++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", c, rd_valid, exp_v);
            end
            if (c >= 3) begin
                kk = (c <= 10) ? c - 3 : 7;
                checks++;
                if (data_out_a !== line_of(0, kk, 0) || data_out_b !== exp_b(0, kk)) begin
                    failures++;
                    $display("FAIL stream_data line=%0d a got=%h exp=%h b1 got=%h exp=%h", kk,
                             data_out_a, line_of(0, kk, 0), data_out_b[63:0], line_of(0, kk, 1));
                end
            end
            rd_en   = (c < 8);
            rd_line = 3'(c);
            @(negedge clk);
        end
        rd_en = 1'b0;
    endtask

    task automatic test_ping_pong();
        fill_buffer(1);
        pulse_commit();
        checks++; if (fill_ready !== 1'b0) begin failures++; $display("FAIL pp_full_fill_ready got=%b exp=0", fill_ready); end
        checks++; if (rd_avail !== 1'b1) begin failures++; $display("FAIL pp_full_rd_avail got=%b exp=1", rd_avail); end
        checks++; if (err_wr !== 1'b0) begin failures++; $display("FAIL pp_no_err_yet got=%b exp=0", err_wr); end
        write_word(mk_addr(3, 0, 0), 32'hDEAD_BEEF);
        checks++; if (err_wr !== 1'b1) begin failures++; $display("FAIL pp_err_wr got=%b exp=1", err_wr); end
        checks++; if (err_addr !== 1'b0) begin failures++; $display("FAIL pp_err_addr got=%b exp=0", err_addr); end
        pulse_done();
        checks++; if (fill_ready !== 1'b1) begin failures++; $display("FAIL pp_done_fill_ready got=%b exp=1", fill_ready); end
        checks++; if (rd_avail !== 1'b1) begin failures++; $display("FAIL pp_done_rd_avail got=%b exp=1", rd_avail); end
        rd_en = 1'b1; rd_line = 3'd3;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL pp_latency_early got=%b exp=0", rd_valid); end
        @(negedge clk);
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL pp_rd_valid got=%b exp=1", rd_valid); end
        checks++;
        if (data_out_a !== line_of(1, 3, 0) || data_out_b !== exp_b(1, 3)) begin
            failures++;
            $display("FAIL pp_buf1_data a got=%h exp=%h b1 got=%h exp=%h",
                     data_out_a, line_of(1, 3, 0), data_out_b[63:0], line_of(1, 3, 1));
        end
        pulse_err_clr();
        checks++; if (err_wr !== 1'b0) begin failures++; $display("FAIL pp_err_clr got=%b exp=0", err_wr); end
    endtask

    // Buffer 1 FULL for reading, buffer 0 being filled: commit and rd_done together.
    task automatic test_commit_done_same_cycle();
        write_word(mk_addr(0, 0, 0), 32'h1111_0000);
        write_word(mk_addr(0, 0, 1), 32'h1111_0001);
        commit = 1'b1; rd_done = 1'b1;
        @(negedge clk);
        commit = 1'b0; rd_done = 1'b0;
        checks++; if (fill_ready !== 1'b1) begin failures++; $display("FAIL same_fill_ready got=%b exp=1", fill_ready); end
        checks++; if (rd_avail !== 1'b1) begin failures++; $display("FAIL same_rd_avail got=%b exp=1", rd_avail); end
        // Read and release in the same cycle: the read still completes from buffer 0.
        rd_en = 1'b1; rd_line = 3'd0; rd_done = 1'b1;
        @(negedge clk);
        rd_en = 1'b0; rd_done = 1'b0;
        checks++; if (rd_avail !== 1'b0) begin failures++; $display("FAIL same_released_avail got=%b exp=0", rd_avail); end
        checks++; if (fill_ready !== 1'b1) begin failures++; $display("FAIL same_released_fill got=%b exp=1", fill_ready); end
        repeat (2) @(negedge clk);
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL same_rd_valid got=%b exp=1", rd_valid); end
        checks++;
        if (data_out_a !== 64'h1111_0001_1111_0000 || data_out_b !== exp_b(0, 0)) begin
            failures++;
            $display("FAIL same_data a got=%h exp=%h b1 got=%h exp=%h",
                     data_out_a, 64'h1111_0001_1111_0000, data_out_b[63:0], line_of(0, 0, 1));
        end
        rd_en = 1'b1; rd_line = 3'd5;
        @(negedge clk);
        rd_en = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL idle_read_valid got=%b exp=0", rd_valid); end
        checks++; if (data_out_a !== 64'h1111_0001_1111_0000) begin failures++; $display("FAIL idle_read_hold got=%h exp=%h", data_out_a, 64'h1111_0001_1111_0000); end
    endtask

    task automatic test_bad_bank();
        write_word({3'd2, 7'd65, 1'b0}, 32'h0BAD_0BAD);
        checks++; if (err_addr !== 1'b1) begin failures++; $display("FAIL bad_err_addr got=%b exp=1", err_addr); end
        checks++; if (err_wr !== 1'b0) begin failures++; $display("FAIL bad_err_wr got=%b exp=0", err_wr); end
        pulse_commit();
        checks++; if (rd_avail !== 1'b1) begin failures++; $display("FAIL bad_rd_avail got=%b exp=1", rd_avail); end
        rd_en = 1'b1; rd_line = 3'd2;
        @(negedge clk);
        rd_en = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL bad_rd_valid got=%b exp=1", rd_valid); end
        checks++;
        if (data_out_a !== line_of(1, 2, 0) || data_out_b !== exp_b(1, 2)) begin
            failures++;
            $display("FAIL bad_ram_unchanged a got=%h exp=%h b1 got=%h exp=%h",
                     data_out_a, line_of(1, 2, 0), data_out_b[63:0], line_of(1, 2, 1));
        end
        pulse_err_clr();
        checks++; if (err_addr !== 1'b0) begin failures++; $display("FAIL bad_err_clr got=%b exp=0", err_addr); end
        err_clr = 1'b1;
        write_word({3'd1, 7'd70, 1'b1}, 32'h0000_BAD1);
        err_clr = 1'b0;
        checks++; if (err_addr !== 1'b1) begin failures++; $display("FAIL bad_clr_collide got=%b exp=1", err_addr); end
        pulse_err_clr();
        checks++; if (err_addr !== 1'b0) begin failures++; $display("FAIL bad_final_clr got=%b exp=0", err_addr); end
    endtask

    task automatic test_reset_mid_read();
        rd_en = 1'b1; rd_line = 3'd4;
        @(negedge clk);
        rd_en = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid0 got=%b exp=0", rd_valid); end
        @(negedge clk);
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid1 got=%b exp=0", rd_valid); end
        checks++; if (data_out_a !== '0) begin failures++; $display("FAIL rstmid_data_a got=%h exp=0", data_out_a); end
        checks++; if (data_out_b !== '0) begin failures++; $display("FAIL rstmid_data_b bank1 got=%h exp=0", data_out_b[63:0]); end
        checks++; if (fill_ready !== 1'b1) begin failures++; $display("FAIL rstmid_fill_ready got=%b exp=1", fill_ready); end
        checks++; if (rd_avail !== 1'b0) begin failures++; $display("FAIL rstmid_rd_avail got=%b exp=0", rd_avail); end
        rd_en = 1'b1; rd_line = 3'd4;
        @(negedge clk);
        rd_en = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale_read got=%b exp=0", rd_valid); end
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
        rd_en = 1'b0; rd_line = '0; rd_done = 1'b0; err_clr = 1'b0;
        test_reset();
        test_fill_read_stream();
        test_ping_pong();
        test_commit_done_same_cycle();
        test_bad_bank();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
